// File: rtl/ifu_pkg.sv
// Shared types and default parameters for the instruction-fetch unit.
package ifu_pkg;
  localparam int          IFU_ADDR_W   = 32;
  localparam int          IFU_DATA_W   = 32;
  localparam logic [31:0] IFU_RESET_PC = 32'h0000_0000;
  localparam int          IFU_PC_STEP  = 4;

  typedef enum logic [1:0] {RESET_WAIT, FETCH, WAIT_ACK, HOLD} ifu_state_e;
endpackage

// File: rtl/ifu_pc_reg.sv
// Fetch PC holding register; loads d when load=1, synchronous active-low reset to RESET_PC.
module ifu_pc_reg
  import ifu_pkg::*;
#(
  parameter int                ADDR_W   = IFU_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IFU_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] d,
  output logic [ADDR_W-1:0] q
);
  always_ff @(posedge clk) begin
    if (!rst_n)    q <= RESET_PC;
    else if (load) q <= d;
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch sequencer: next-PC select, req/ack imem read, 1-entry decode buffer; ack->instr_valid 1 cycle.
// Stalls when the buffer is not free or stall_i=1; optional IFU_MISALIGN_CHECK_EN flags misaligned redirects.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int                ADDR_W   = IFU_ADDR_W,
  parameter int                DATA_W   = IFU_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IFU_RESET_PC),
  parameter int                PC_STEP  = IFU_PC_STEP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] pc_o,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              misalign_err
);
  ifu_state_e        state, state_nxt;
  logic              buf_free;
  logic              ack_fire;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] redirect_aligned;

  assign buf_free         = !instr_valid || instr_ready;
  assign redirect_aligned = redirect_pc & ~ADDR_W'(3);
  assign imem_addr        = pc_o;
  assign ack_fire         = imem_req && imem_ack;

  // A redirect always wins: the coincident ack is dropped and the PC is not stepped.
  assign pc_load = redirect_valid || ack_fire;
  assign pc_nxt  = redirect_valid ? redirect_aligned : pc_o + ADDR_W'(PC_STEP);

  ifu_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (pc_load),
    .d     (pc_nxt),
    .q     (pc_o)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= RESET_WAIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    case (state)
      RESET_WAIT: state_nxt = FETCH;
      FETCH: begin
        // A new request only goes out when the buffer can take its data.
        imem_req = buf_free && !stall_i;
        if (imem_req) state_nxt = imem_ack ? (instr_ready ? FETCH : HOLD) : WAIT_ACK;
      end
      WAIT_ACK: begin
        imem_req = 1'b1;
        if (imem_ack) state_nxt = instr_ready ? FETCH : HOLD;
      end
      HOLD: if (buf_free && !stall_i) state_nxt = FETCH;
      default: state_nxt = RESET_WAIT;
    endcase
    if (redirect_valid) state_nxt = stall_i ? HOLD : FETCH;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_valid <= 1'b0;
      instr_o     <= '0;
      instr_pc    <= '0;
    end else if (redirect_valid) begin
      instr_valid <= 1'b0;
    end else if (ack_fire) begin
      instr_valid <= 1'b1;
      instr_o     <= imem_rdata;
      instr_pc    <= pc_o;
    end else if (instr_ready) begin
      instr_valid <= 1'b0;
    end
  end

`ifdef IFU_MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      misalign_err <= 1'b0;
    else if (redirect_valid && (redirect_pc[1:0] != 2'b00))
      misalign_err <= 1'b1;
  end
`else
  assign misalign_err = 1'b0;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboarded bench for instr_fetch_unit: directed scenarios followed by random traffic.
module tb_instr_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef IFU_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } item_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc_o;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_o;
  logic [31:0] instr_pc;
  logic        misalign_err;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          n_push = 0;
  item_t       exp_q[$];
  logic [31:0] exp_pc = RST_PC;
  bit          exp_mis = 1'b0;
  bit          outstanding = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  instr_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_i        (stall_i),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc_o           (pc_o),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_o        (instr_o),
    .instr_pc       (instr_pc),
    .misalign_err   (misalign_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the decode-side output against the scoreboard and retires accepted items.
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      check("instr_valid", 32'(instr_valid), 32'(exp_q.size() != 0));
      if (instr_valid && exp_q.size() != 0) begin
        check("instr_pc", instr_pc, exp_q[0].pc);
        check("instr_o", instr_o, exp_q[0].word);
        if (instr_ready) void'(exp_q.pop_front());
      end
      check("pc_o", pc_o, exp_pc);
      check("misalign_err", 32'(misalign_err), 32'(exp_mis));
    end
  end

  // Drive one cycle of stimulus, then update the reference model for the coming edge.
  task automatic cycle(input bit rst, input bit st, input bit rdy, input bit rv,
                       input logic [31:0] rpc, input bit ack);
    bit fire;
    @(negedge clk);
    rst_n          = !rst;
    stall_i        = st;
    instr_ready    = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_ack       = ack;
    #2;
    if (!rst_n) begin
      exp_q.delete();
      exp_pc      = RST_PC;
      exp_mis     = 1'b0;
      outstanding = 1'b0;
    end else begin
      if (outstanding)
        check("req_held", 32'(imem_req), 32'd1);
      else if (st || (instr_valid && !rdy))
        check("req_blocked", 32'(imem_req), 32'd0);
      if (imem_req) check("imem_addr", imem_addr, exp_pc);
      fire = imem_req && ack;
      if (rv) begin
        exp_q.delete();
        exp_pc = rpc & 32'hFFFF_FFFC;
        if (rpc[1:0] != 2'b00 && MIS_EN) exp_mis = 1'b1;
        outstanding = 1'b0;
      end else begin
        if (fire) begin
          exp_q.push_back('{pc: exp_pc, word: mem_word(exp_pc)});
          exp_pc = exp_pc + 32'd4;
          n_push++;
        end
        outstanding = imem_req && !ack;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; stall_i = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    instr_ready = 1'b0; imem_ack = 1'b0;
    repeat (3) cycle(1, 0, 0, 0, 32'h0, 0);
    check("rst_pc_o", pc_o, RST_PC);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_imem_addr", imem_addr, RST_PC);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr_o", instr_o, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    check("rst_misalign", 32'(misalign_err), 32'd0);

    // Back-to-back fetch: one wait cycle out of reset, then one instruction per cycle.
    n_push = 0;
    repeat (10) cycle(0, 0, 1, 0, 32'h0, 1);
    check("throughput", n_push, 32'd9);

    // Decode backpressure holds the buffer and blocks new requests.
    repeat (4) cycle(0, 0, 0, 0, 32'h0, 1);
    repeat (2) cycle(0, 0, 1, 0, 32'h0, 1);

    // Slow memory: request stays up (even under stall) until acked.
    cycle(0, 0, 1, 0, 32'h0, 0);
    cycle(0, 1, 1, 0, 32'h0, 0);
    cycle(0, 0, 1, 0, 32'h0, 0);
    cycle(0, 0, 1, 0, 32'h0, 1);

    // Redirect coincident with an ack drops the data.
    cycle(0, 0, 1, 1, 32'h0000_0100, 1);
    repeat (3) cycle(0, 0, 1, 0, 32'h0, 1);

    // PC wrap at the top of the address space.
    cycle(0, 0, 1, 1, 32'hFFFF_FFFC, 0);
    repeat (3) cycle(0, 0, 1, 0, 32'h0, 1);

    // Misaligned redirect, then a one-cycle reset clears everything.
    cycle(0, 0, 1, 1, 32'h0000_0102, 0);
    repeat (2) cycle(0, 0, 1, 0, 32'h0, 1);
    cycle(1, 0, 1, 0, 32'h0, 1);
    repeat (3) cycle(0, 0, 1, 0, 32'h0, 1);

    n_push = 0;
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
      cycle($urandom_range(0, 199) == 0,
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 9) < 7,
            $urandom_range(0, 19) == 0,
            rpc,
            $urandom_range(0, 9) < 6);
    end
    if (n_push < 100) begin
      n_fail++;
      $display("FAIL progress: got %0d fetches expected at least 100", n_push);
    end
    n_chk++;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
